// File: rtl/control_unit_pkg.sv
// Shared encodings for the SimpleRISC decoder: opcode map, ALU one-hot bit positions,
// and the packed control word passed from the decode logic to the output register.
package control_unit_pkg;

  localparam int ALU_W = 15;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_MUL  = 5'd2;
  localparam logic [4:0] OP_DIV  = 5'd3;
  localparam logic [4:0] OP_MOD  = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd5;
  localparam logic [4:0] OP_AND  = 5'd6;
  localparam logic [4:0] OP_OR   = 5'd7;
  localparam logic [4:0] OP_NOT  = 5'd8;
  localparam logic [4:0] OP_MOV  = 5'd9;
  localparam logic [4:0] OP_LSL  = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_NOP  = 5'd13;
  localparam logic [4:0] OP_LD   = 5'd14;
  localparam logic [4:0] OP_ST   = 5'd15;
  localparam logic [4:0] OP_BEQ  = 5'd16;
  localparam logic [4:0] OP_BGT  = 5'd17;
  localparam logic [4:0] OP_B    = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;

  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_MUL     = 4'd2;
  localparam logic [3:0] ALU_DIV     = 4'd3;
  localparam logic [3:0] ALU_MOD     = 4'd4;
  localparam logic [3:0] ALU_CMP     = 4'd5;
  localparam logic [3:0] ALU_AND     = 4'd6;
  localparam logic [3:0] ALU_OR      = 4'd7;
  localparam logic [3:0] ALU_NOT     = 4'd8;
  localparam logic [3:0] ALU_MOV     = 4'd9;
  localparam logic [3:0] ALU_LSL     = 4'd10;
  localparam logic [3:0] ALU_LSR     = 4'd11;
  localparam logic [3:0] ALU_ASR     = 4'd12;
  localparam logic [3:0] ALU_NOP     = 4'd13;
  localparam logic [3:0] ALU_ILLEGAL = 4'd14;

  typedef struct packed {
    logic [ALU_W-1:0] alu;
    logic             is_ret;
    logic             is_st;
    logic             is_wb;
    logic             is_beq;
    logic             is_bgt;
    logic             is_ubranch;
    logic             is_ld;
    logic             is_call;
    logic             is_imm;
  } ctrl_t;

  function automatic logic [ALU_W-1:0] alu_bit(input logic [3:0] idx);
    alu_bit = 15'h0001 << idx;
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Pure combinational decode of (opcode, I) into the next control word.
module cu_decode_comb
  import control_unit_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic       imm_bit,
  output ctrl_t      ctrl_next
);

  // Map opcode to ALU one-hot and datapath/branch flags; unknown opcodes fall to illegal.
  always_comb begin
    ctrl_next = '0;
    if (opcode <= OP_ASR) begin
      ctrl_next.alu    = alu_bit(opcode[3:0]);
      ctrl_next.is_wb  = (opcode != OP_CMP);
      ctrl_next.is_imm = imm_bit;
    end else begin
      case (opcode)
        OP_NOP: ctrl_next.alu = alu_bit(ALU_NOP);
        OP_LD: begin
          // Memory address is formed by the ALU as rs1 + imm.
          ctrl_next.alu    = alu_bit(ALU_ADD);
          ctrl_next.is_ld  = 1'b1;
          ctrl_next.is_wb  = 1'b1;
          ctrl_next.is_imm = imm_bit;
        end
        OP_ST: begin
          ctrl_next.alu    = alu_bit(ALU_ADD);
          ctrl_next.is_st  = 1'b1;
          ctrl_next.is_imm = imm_bit;
        end
        OP_BEQ: ctrl_next.is_beq = 1'b1;
        OP_BGT: ctrl_next.is_bgt = 1'b1;
        OP_B:   ctrl_next.is_ubranch = 1'b1;
        OP_CALL: begin
          ctrl_next.is_call    = 1'b1;
          ctrl_next.is_ubranch = 1'b1;
          ctrl_next.is_wb      = 1'b1;
        end
        OP_RET: begin
          ctrl_next.is_ret     = 1'b1;
          ctrl_next.is_ubranch = 1'b1;
        end
        default: ctrl_next.alu = alu_bit(ALU_ILLEGAL);
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// SimpleRISC instruction decoder: combinational decode captured into a registered
// control word, cleared by synchronous reset.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  opcode,
  input  logic        I,
  output logic [14:0] aluSignals,
  output logic        isRet,
  output logic        isSt,
  output logic        isWb,
  output logic        isBeq,
  output logic        isBgt,
  output logic        isUBranch,
  output logic        isLd,
  output logic        isCall,
  output logic        isImmediate
);

  ctrl_t ctrl_next_s;
  ctrl_t ctrl_r;

  cu_decode_comb u_decode (
    .opcode    (opcode),
    .imm_bit   (I),
    .ctrl_next (ctrl_next_s)
  );

  // Output register; reset wins over the decode presented at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r <= '0;
    end else begin
      ctrl_r <= ctrl_next_s;
    end
  end

  assign aluSignals  = ctrl_r.alu;
  assign isRet       = ctrl_r.is_ret;
  assign isSt        = ctrl_r.is_st;
  assign isWb        = ctrl_r.is_wb;
  assign isBeq       = ctrl_r.is_beq;
  assign isBgt       = ctrl_r.is_bgt;
  assign isUBranch   = ctrl_r.is_ubranch;
  assign isLd        = ctrl_r.is_ld;
  assign isCall      = ctrl_r.is_call;
  assign isImmediate = ctrl_r.is_imm;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed vectors over the full opcode map,
// reset behaviour and the illegal range.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  opcode;
  logic        I;
  logic [14:0] aluSignals;
  logic        isRet, isSt, isWb, isBeq, isBgt, isUBranch, isLd, isCall, isImmediate;

  int checks;
  int failures;

  control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .I           (I),
    .aluSignals  (aluSignals),
    .isRet       (isRet),
    .isSt        (isSt),
    .isWb        (isWb),
    .isBeq       (isBeq),
    .isBgt       (isBgt),
    .isUBranch   (isUBranch),
    .isLd        (isLd),
    .isCall      (isCall),
    .isImmediate (isImmediate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: {ret, st, wb, beq, bgt, ubranch, ld, call, imm}
  task automatic check_out(input string tag, input logic [14:0] exp_alu, input logic [8:0] exp_flags);
    logic [8:0] flags;
    flags = {isRet, isSt, isWb, isBeq, isBgt, isUBranch, isLd, isCall, isImmediate};
    checks++;
    assert (aluSignals === exp_alu)
    else begin
      failures++;
      $error("FAIL %s alu got=%h exp=%h", tag, aluSignals, exp_alu);
    end
    checks++;
    assert (flags === exp_flags)
    else begin
      failures++;
      $error("FAIL %s flags got=%b exp=%b", tag, flags, exp_flags);
    end
  endtask

  task automatic step(input string tag, input logic [4:0] op, input logic imm,
                      input logic [14:0] exp_alu, input logic [8:0] exp_flags);
    opcode = op;
    I      = imm;
    @(posedge clk);
    #1;
    check_out(tag, exp_alu, exp_flags);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    opcode   = 5'd0;
    I        = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_out("reset", 15'h0000, 9'h000);

    rst = 1'b0;
    step("add_i0",  5'd0,  1'b0, 15'h0001, 9'h040);
    step("add_i1",  5'd0,  1'b1, 15'h0001, 9'h041);
    step("sub",     5'd1,  1'b0, 15'h0002, 9'h040);
    step("mul",     5'd2,  1'b1, 15'h0004, 9'h041);
    step("div",     5'd3,  1'b0, 15'h0008, 9'h040);
    step("mod",     5'd4,  1'b1, 15'h0010, 9'h041);
    step("cmp",     5'd5,  1'b1, 15'h0020, 9'h001);
    step("and",     5'd6,  1'b0, 15'h0040, 9'h040);
    step("or",      5'd7,  1'b1, 15'h0080, 9'h041);
    step("not",     5'd8,  1'b0, 15'h0100, 9'h040);
    step("mov",     5'd9,  1'b1, 15'h0200, 9'h041);
    step("lsl",     5'd10, 1'b0, 15'h0400, 9'h040);
    step("lsr",     5'd11, 1'b0, 15'h0800, 9'h040);
    step("asr",     5'd12, 1'b1, 15'h1000, 9'h041);
    step("nop",     5'd13, 1'b1, 15'h2000, 9'h000);
    step("ld",      5'd14, 1'b1, 15'h0001, 9'h045);
    step("st_i0",   5'd15, 1'b0, 15'h0001, 9'h080);
    step("st_i1",   5'd15, 1'b1, 15'h0001, 9'h081);
    step("beq",     5'd16, 1'b1, 15'h0000, 9'h020);
    step("bgt",     5'd17, 1'b1, 15'h0000, 9'h010);
    step("b",       5'd18, 1'b1, 15'h0000, 9'h008);
    step("call",    5'd19, 1'b1, 15'h0000, 9'h04A);
    step("ret",     5'd20, 1'b1, 15'h0000, 9'h108);
    step("ill21",   5'd21, 1'b1, 15'h4000, 9'h000);
    step("ill31",   5'd31, 1'b1, 15'h4000, 9'h000);

    // Reset asserted with CALL presented drops the decode; release gives CALL one edge later.
    rst = 1'b1;
    step("rst_call", 5'd19, 1'b1, 15'h0000, 9'h000);
    rst = 1'b0;
    step("post_rst", 5'd19, 1'b1, 15'h0000, 9'h04A);
    step("post_add", 5'd0,  1'b0, 15'h0001, 9'h040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
